quickq_deq_engine: RTL and testbench

//  Dequeue side of the QuickQ sorted-array priority queue. On a dequeue request it

---
 rtl/quickq_deq_engine.sv | 147 ++++++++++++++
 tb/tb_quickq_deq_engine.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quickq_deq_engine.sv
// quickq_deq_engine: dequeue side of the QuickQ sorted-array priority queue.
// Define QQ_DEQ_CLEAR_EN to add a CLEAR state that zeroes the vacated tail slot.
module quickq_deq_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              deq_req,
  input  logic [ADDR_W:0]   count_in,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid,
  output logic [ADDR_W:0]   count_out,
  output logic              count_we,
  output logic              deq_done,
  output logic              underflow,
  output logic              busy,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_HEAD,
    CAPTURE,
    SHIFT_RD,
    SHIFT_WR,
    CLEAR,
    UPDATE
  } state_t;

`ifdef QQ_DEQ_CLEAR_EN
  localparam state_t PostShift = CLEAR;
`else
  localparam state_t PostShift = UPDATE;
`endif

  localparam logic [ADDR_W:0]   CntOne = 1;
  localparam logic [ADDR_W-1:0] IdxOne = 1;

  state_t              state_q;
  logic [ADDR_W:0]     n_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     last_idx;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                count_we_q;
  logic                done_q;
  logic                underflow_q;
  logic                last_shift;

  assign last_idx   = n_q - CntOne;
  assign last_shift = ({1'b0, idx_q} == last_idx);

  // Sequencer; the latched occupancy n_q isolates the shift from count_in changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      count_we_q  <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      count_we_q  <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (deq_req) begin
            if (count_in == '0) begin
              underflow_q <= 1'b1;
            end else begin
              n_q     <= count_in;
              idx_q   <= IdxOne;
              state_q <= RD_HEAD;
            end
          end
        end
        RD_HEAD: state_q <= CAPTURE;
        CAPTURE: begin
          data_q  <= bram_rdata;
          valid_q <= 1'b1;
          state_q <= (n_q == CntOne) ? PostShift : SHIFT_RD;
        end
        SHIFT_RD: state_q <= SHIFT_WR;
        SHIFT_WR: begin
          idx_q   <= idx_q + IdxOne;
          state_q <= last_shift ? PostShift : SHIFT_RD;
        end
        CLEAR: state_q <= UPDATE;
        UPDATE: begin
          count_q    <= last_idx;
          count_we_q <= 1'b1;
          done_q     <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // BRAM port is decoded from state because SHIFT_WR forwards the read data
  // that only arrives during that same cycle.
  always_comb begin
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    case (state_q)
      RD_HEAD: bram_en = 1'b1;
      SHIFT_RD: begin
        bram_en   = 1'b1;
        bram_addr = idx_q;
      end
      SHIFT_WR: begin
        bram_en    = 1'b1;
        bram_we    = 1'b1;
        bram_addr  = idx_q - IdxOne;
        bram_wdata = bram_rdata;
      end
      CLEAR: begin
        bram_en   = 1'b1;
        bram_we   = 1'b1;
        bram_addr = last_idx[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  assign data_o     = data_q;
  assign data_valid = valid_q;
  assign count_out  = count_q;
  assign count_we   = count_we_q;
  assign deq_done   = done_q;
  assign underflow  = underflow_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_quickq_deq_engine.sv
// Scoreboard testbench for quickq_deq_engine with a behavioural BRAM and
// an array-based reference model of the sorted queue.
module tb_quickq_deq_engine;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int DEPTH = 1 << AW;
`ifdef QQ_DEQ_CLEAR_EN
   localparam int CLR = 1;
`else
   localparam int CLR = 0;
`endif

   logic          clk;
   logic          rst;
   logic          deqReq;
   logic [AW:0]   countIn;
   logic [DW-1:0] dataO;
   logic          dataValid;
   logic [AW:0]   countOut;
   logic          countWe;
   logic          deqDone;
   logic          underflow;
   logic          busy;
   logic          bramEn;
   logic          bramWe;
   logic [AW-1:0] bramAddr;
   logic [DW-1:0] bramWdata;
   logic [DW-1:0] bramRdata;

   logic          tbLoad;
   logic [AW-1:0] tbAddr;
   logic [DW-1:0] tbData;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] refMem [DEPTH];

   int vectors = 0;
   int miscompares = 0;
   int cycleCnt = 0;
   int curCount = 0;

   logic [DW-1:0] expData[$];
   int            expDataCyc[$];
   int            expCount[$];
   int            expDoneCyc[$];
   int            expUnderCyc[$];

   quickq_deq_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk),
      .rst(rst),
      .deq_req(deqReq),
      .count_in(countIn),
      .data_o(dataO),
      .data_valid(dataValid),
      .count_out(countOut),
      .count_we(countWe),
      .deq_done(deqDone),
      .underflow(underflow),
      .busy(busy),
      .bram_en(bramEn),
      .bram_we(bramWe),
      .bram_addr(bramAddr),
      .bram_wdata(bramWdata),
      .bram_rdata(bramRdata)
   );

   // Free-running clock and cycle counter used for latency bookkeeping.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Single-port BRAM with one-cycle read latency; the bench preloads it while idle.
   always @(posedge clk) begin
      if (tbLoad) begin
         mem[tbAddr] <= tbData;
      end else if (bramEn) begin
         if (bramWe) mem[bramAddr] <= bramWdata;
         bramRdata <= mem[bramAddr];
      end
   end

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
      end
   endtask

   // Monitor: pops the scoreboard whenever the engine presents a pulse.
   always @(negedge clk) begin
      if (dataValid) begin
         if (expData.size() == 0) begin
            checkVal("spurious_data_valid", 64'(dataValid), 64'(0));
         end else begin
            checkVal("data_o", 64'(dataO), 64'(expData.pop_front()));
            checkVal("data_valid_cycle", 64'(cycleCnt), 64'(expDataCyc.pop_front()));
         end
      end
      if (deqDone || countWe) begin
         checkVal("count_we_with_done", 64'(countWe), 64'(deqDone));
         if (expCount.size() == 0) begin
            checkVal("spurious_deq_done", 64'(deqDone), 64'(0));
         end else begin
            checkVal("count_out", 64'(countOut), 64'(expCount.pop_front()));
            checkVal("deq_done_cycle", 64'(cycleCnt), 64'(expDoneCyc.pop_front()));
         end
      end
      if (underflow) begin
         if (expUnderCyc.size() == 0)
            checkVal("spurious_underflow", 64'(underflow), 64'(0));
         else
            checkVal("underflow_cycle", 64'(cycleCnt), 64'(expUnderCyc.pop_front()));
      end
   end

   task automatic loadWord(input int addr, input logic [DW-1:0] val);
      @(negedge clk);
      tbLoad = 1'b1;
      tbAddr = AW'(addr);
      tbData = val;
      @(posedge clk);
      #1 tbLoad = 1'b0;
      refMem[addr] = val;
   endtask

   task automatic loadQueue(input int n);
      logic [DW-1:0] v;
      v = 32'hF000_0000;
      for (int a = 0; a < n; a++) begin
         v = v - DW'($urandom_range(1, 5000));
         loadWord(a, v);
      end
      curCount = n;
   endtask

   // Issues one dequeue of occupancy n and pushes the model's expectations.
   task automatic applyStimulus(input int n, input bit poke);
      int c0;
      @(negedge clk);
      countIn = (AW+1)'(n);
      deqReq  = 1'b1;
      @(posedge clk);
      #1 c0 = cycleCnt;
      deqReq  = 1'b0;
      countIn = (AW+1)'($urandom_range(0, DEPTH));
      checkVal("busy_after_req", 64'(busy), 64'(n != 0));
      if (n == 0) begin
         checkVal("underflow_no_bram", 64'(bramEn), 64'(0));
         expUnderCyc.push_back(c0);
      end else begin
         expData.push_back(refMem[0]);
         expDataCyc.push_back(c0 + 2);
         expCount.push_back(n - 1);
         expDoneCyc.push_back(c0 + 3 + 2 * (n - 1) + CLR);
         for (int i = 0; i < n - 1; i++) refMem[i] = refMem[i + 1];
         if (CLR == 1) refMem[n - 1] = '0;
      end
      if (poke) begin
         repeat (4) begin
            @(negedge clk);
            deqReq  = 1'b1;
            countIn = (AW+1)'(5);
         end
         @(negedge clk);
         deqReq = 1'b0;
      end
      for (int k = 0; k < 200 && (expData.size() + expCount.size() + expUnderCyc.size()) != 0; k++)
         @(posedge clk);
      checkVal("drain_timeout", 64'(expData.size() + expCount.size() + expUnderCyc.size()), 64'(0));
      repeat (3) @(posedge clk);
      curCount = (n == 0) ? 0 : n - 1;
   endtask

   task automatic checkOutput(input string tag);
      #1;
      for (int a = 0; a < DEPTH; a++)
         checkVal($sformatf("%s_bram[%0d]", tag, a), 64'(mem[a]), 64'(refMem[a]));
      checkVal({tag, "_idle_busy"}, 64'(busy), 64'(0));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit sawWe;
      rst = 1'b1;
      deqReq = 1'b0;
      countIn = '0;
      tbLoad = 1'b0;
      tbAddr = '0;
      tbData = '0;
      for (int a = 0; a < DEPTH; a++) refMem[a] = '0;
      for (int a = 0; a < DEPTH; a++) loadWord(a, '0);

      #1;
      checkVal("rst_data_o", 64'(dataO), 64'(0));
      checkVal("rst_data_valid", 64'(dataValid), 64'(0));
      checkVal("rst_count_out", 64'(countOut), 64'(0));
      checkVal("rst_count_we", 64'(countWe), 64'(0));
      checkVal("rst_deq_done", 64'(deqDone), 64'(0));
      checkVal("rst_underflow", 64'(underflow), 64'(0));
      checkVal("rst_busy", 64'(busy), 64'(0));
      checkVal("rst_bram_en", 64'(bramEn), 64'(0));
      checkVal("rst_bram_we", 64'(bramWe), 64'(0));
      checkVal("rst_bram_addr", 64'(bramAddr), 64'(0));
      checkVal("rst_bram_wdata", 64'(bramWdata), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset released");

      applyStimulus(0, 1'b0);
      checkOutput("empty");

      loadWord(0, 32'h55);
      applyStimulus(1, 1'b0);
      checkOutput("single");

      loadWord(0, 32'd40);
      loadWord(1, 32'd30);
      loadWord(2, 32'd20);
      applyStimulus(3, 1'b0);
      checkOutput("shift");

      loadWord(0, 32'd9);
      loadWord(1, 32'd7);
      loadWord(2, 32'd5);
      applyStimulus(3, 1'b0);
      applyStimulus(2, 1'b0);
      checkOutput("b2b");

      loadWord(0, 32'd40);
      loadWord(1, 32'd30);
      loadWord(2, 32'd20);
      applyStimulus(3, 1'b1);
      checkOutput("busy_ignore");

      loadQueue(DEPTH);
      applyStimulus(DEPTH, 1'b0);
      checkOutput("full");

      for (int it = 0; it < 30; it++) begin
         if (curCount > 0 && $urandom_range(0, 1) == 1) begin
            applyStimulus(curCount, 1'b0);
         end else begin
            loadQueue($urandom_range(0, DEPTH));
            applyStimulus(curCount, 1'b0);
         end
         checkOutput("rand");
      end

      // Abort a shift in progress with reset and expect everything cleared.
      loadQueue(6);
      @(negedge clk);
      countIn = (AW+1)'(6);
      deqReq = 1'b1;
      @(posedge clk);
      #1 expData.push_back(refMem[0]);
      expDataCyc.push_back(cycleCnt + 2);
      deqReq = 1'b0;
      sawWe = 1'b0;
      for (int k = 0; k < 20 && !sawWe; k++) begin
         @(posedge clk);
         #1 if (bramWe) sawWe = 1'b1;
      end
      checkVal("reach_shift_wr", 64'(sawWe), 64'(1));
      rst = 1'b1;
      #1;
      checkVal("abort_data_o", 64'(dataO), 64'(0));
      checkVal("abort_count_out", 64'(countOut), 64'(0));
      checkVal("abort_busy", 64'(busy), 64'(0));
      checkVal("abort_bram_en", 64'(bramEn), 64'(0));
      checkVal("abort_bram_we", 64'(bramWe), 64'(0));
      checkVal("abort_bram_addr", 64'(bramAddr), 64'(0));
      checkVal("abort_bram_wdata", 64'(bramWdata), 64'(0));
      checkVal("abort_pending_data", 64'(expData.size()), 64'(0));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      loadQueue(DEPTH);
      applyStimulus(DEPTH, 1'b0);
      checkOutput("post_abort");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
